uart_rx_fifo_engine: RTL and testbench

Parametrised next-generation UART receive path. It integrates start detection, oversample bit timing, 3-sample majority voting, 5–8 bit framing, parity/framing/break checking and a show-ahead receive FIFO that stores per-character error status. It takes a raw oversample tick from the baud generator, replacing the external sample_edge/voting_edge scheme, and feeds the register block's receive buffer/LSR logic.

---
 rtl/uart_rx_fifo_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_engine.sv
// uart_rx_fifo_engine
// UART receive path: line select + synchroniser, oversampled bit timing with
// 3-sample majority vote, 5..8 bit framing with optional parity, framing and
// break detection, and a show-ahead receive FIFO holding {bi,fe,pe,data}.
//
// Ports:
//   pclk, presetn      clock, asynchronous active-low reset
//   utrrst             synchronous receiver reset / FIFO flush
//   baud_tick          one-cycle pulse at OVS x baud rate
//   uart_rxd, loop_txd serial inputs (loop selects loop_txd)
//   wls, pen, eps, sp  line control: word length-5, parity enable/even/stick
//   rd_en              pop the FIFO head
//   rx_data/pe/fe/bi   head character and its status (0 when empty)
//   rx_valid           FIFO not empty
//   fifo_count         entries held (0..DEPTH)
//   overrun            sticky overrun flag
//   rx_busy            receiver not idle
module uart_rx_fifo_engine #(
    parameter int  OVS   = 16,
    parameter int  DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          utrrst,
    input  logic          baud_tick,
    input  logic          uart_rxd,
    input  logic          loop_txd,
    input  logic          loop,
    input  logic [1:0]    wls,
    input  logic          pen,
    input  logic          eps,
    input  logic          sp,
    input  logic          rd_en,
    output logic [7:0]    rx_data,
    output logic          rx_pe,
    output logic          rx_fe,
    output logic          rx_bi,
    output logic          rx_valid,
    output logic [CW-1:0] fifo_count,
    output logic          overrun,
    output logic          rx_busy
);

    localparam int TW = $clog2(OVS);
    localparam int AW = $clog2(DEPTH);
    localparam logic [TW-1:0] T_S0   = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVS / 2);
    localparam logic [TW-1:0] T_DEC  = TW'(OVS / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    // ---------------- receiver registers ----------------
    state_t          state_reg, state_next;
    logic            sync1_reg, sync2_reg, prev_reg;
    logic [TW-1:0]   tick_reg, tick_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      shift_reg, shift_next;
    logic            par_reg, par_next;
    logic [1:0]      samp_reg, samp_next;

    logic            vote, at_dec, at_wrap, push_req;
    logic [2:0]      last_bit;
    logic            exp_par, ent_pe, ent_fe, ent_bi;
    logic [10:0]     entry;

    // Third sample is the live synchronised line at the decision tick.
    assign vote    = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & sync2_reg) |
                     (samp_reg[1] & sync2_reg);
    assign at_dec  = baud_tick && (tick_reg == T_DEC);
    assign at_wrap = baud_tick && (tick_reg == T_LAST);
    assign last_bit = {1'b0, wls} + 3'd4;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
            state_reg <= S_IDLE;
            tick_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            par_reg   <= 1'b0;
            samp_reg  <= 2'b11;
        end else begin
            sync1_reg <= loop ? loop_txd : uart_rxd;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            par_reg   <= par_next;
            samp_reg  <= samp_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        par_next   = par_reg;
        samp_next  = samp_reg;
        push_req   = 1'b0;

        if (state_reg != S_IDLE && state_reg != S_WAIT_HIGH && baud_tick) begin
            tick_next = (tick_reg == T_LAST) ? '0 : tick_reg + TW'(1);
            if (tick_reg == T_S0) samp_next[0] = sync2_reg;
            if (tick_reg == T_S1) samp_next[1] = sync2_reg;
        end

        case (state_reg)
            S_IDLE: begin
                if (prev_reg && !sync2_reg) begin
                    state_next = S_START;
                    tick_next  = '0;
                    bit_next   = '0;
                    shift_next = '0;
                    par_next   = 1'b0;
                end
            end
            S_START: begin
                if (at_dec && vote) begin
                    state_next = S_IDLE;        // false start
                    tick_next  = '0;
                end else if (at_wrap) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (at_dec) shift_next[bit_reg] = vote;
                if (at_wrap) begin
                    if (bit_reg == last_bit) state_next = pen ? S_PARITY : S_STOP;
                    else                     bit_next   = bit_reg + 3'd1;
                end
            end
            S_PARITY: begin
                if (at_dec)  par_next   = vote;
                if (at_wrap) state_next = S_STOP;
            end
            S_STOP: begin
                // Character is complete at the stop-bit decision; the rest of
                // the stop bit is not timed, WAIT_HIGH absorbs it.
                if (at_dec) begin
                    push_req   = 1'b1;
                    state_next = S_WAIT_HIGH;
                    tick_next  = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (sync2_reg) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        if (utrrst) begin
            state_next = S_IDLE;
            tick_next  = '0;
        end
    end

    // Unreceived bits of shift_reg stay 0, so the XOR covers only the word.
    always_comb begin
        exp_par = sp ? ~eps : (eps ? ^shift_reg : ~^shift_reg);
        ent_pe  = pen & (par_reg != exp_par);
        ent_fe  = ~vote;
        ent_bi  = ~vote & (shift_reg == 8'h00) & (~pen | ~par_reg);
        entry   = {ent_bi, ent_fe, ent_pe, shift_reg};
    end

    // ---------------- receive FIFO ----------------
    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          ovr_reg;
    logic          full, empty, do_pop, do_push, ovr_set;
    logic [10:0]   head;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_req && (!full || do_pop);
    assign ovr_set = push_req && full && !do_pop;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovr_reg    <= 1'b0;
        end else if (utrrst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovr_reg    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
            else if (!do_push && do_pop) count_reg <= count_reg - CW'(1);
            if (ovr_set) ovr_reg <= 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (do_push && !utrrst) mem[wr_ptr_reg] <= entry;
    end

    assign head       = empty ? 11'd0 : mem[rd_ptr_reg];
    assign rx_data    = head[7:0];
    assign rx_pe      = head[8];
    assign rx_fe      = head[9];
    assign rx_bi      = head[10];
    assign rx_valid   = !empty;
    assign fifo_count = count_reg;
    assign overrun    = ovr_reg;
    assign rx_busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_engine.sv
module tb_uart_rx_fifo_engine;
    localparam int OVS   = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          utrrst = 1'b0;
    logic          baud_tick = 1'b0;
    logic          line_drv = 1'b1;
    logic          use_loop = 1'b0;
    logic          uart_rxd, loop_txd, loop;
    logic [1:0]    wls = 2'b11;
    logic          pen = 1'b0, eps = 1'b0, sp = 1'b0, rd_en = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_pe, rx_fe, rx_bi, rx_valid, overrun, rx_busy;
    logic [CW-1:0] fifo_count;

    assign uart_rxd = use_loop ? 1'b0 : line_drv;
    assign loop_txd = use_loop ? line_drv : 1'b1;
    assign loop     = use_loop;

    uart_rx_fifo_engine #(.OVS(OVS), .DEPTH(DEPTH)) dut (
        .pclk(pclk), .presetn(presetn), .utrrst(utrrst), .baud_tick(baud_tick),
        .uart_rxd(uart_rxd), .loop_txd(loop_txd), .loop(loop), .wls(wls),
        .pen(pen), .eps(eps), .sp(sp), .rd_en(rd_en), .rx_data(rx_data),
        .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi), .rx_valid(rx_valid),
        .fifo_count(fifo_count), .overrun(overrun), .rx_busy(rx_busy)
    );

    always #5 pclk = ~pclk;

    int div = 0;
    always @(posedge pclk) begin
        div       <= (div + 1) % 4;
        baud_tick <= (div == 3);
    end

    int n_total = 0;
    int n_bad   = 0;
    int nbits_cur = 8;

    // Reference model: queue of expected FIFO entries {bi,fe,pe,data}
    logic [10:0] exp_q[$];
    logic        exp_ovr = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [10:0] model_entry(input logic [7:0] d, input int nbits,
            input bit pen_i, input bit eps_i, input bit sp_i, input bit pbit, input bit stopb);
        logic [7:0] dm;
        int ones;
        bit ep, pe_o, fe_o, bi_o;
        dm = d & 8'((1 << nbits) - 1);
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(dm[i]);
        if (sp_i)       ep = !eps_i;
        else if (eps_i) ep = (ones % 2) == 1;   // even: total ones incl. parity even
        else            ep = (ones % 2) == 0;   // odd
        pe_o = pen_i && (pbit != ep);
        fe_o = !stopb;
        bi_o = (dm == 8'h00) && (!pen_i || !pbit) && !stopb;
        return {bi_o, fe_o, pe_o, dm};
    endfunction

    task automatic wait_tick(input int n);
        repeat (n) begin
            @(negedge pclk);
            while (baud_tick !== 1'b1) @(negedge pclk);
        end
    endtask

    task automatic send_bit(input logic b);
        line_drv = b;
        wait_tick(OVS);
    endtask

    task automatic cfg(input logic [1:0] w, input bit p, input bit e, input bit s);
        wls = w; pen = p; eps = e; sp = s;
        nbits_cur = int'(w) + 5;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pbit, input bit stopb,
                              input int glitch_bit, input bit pop_at_push);
        logic [10:0] e;
        e = model_entry(d, nbits_cur, pen, eps, sp, pbit, stopb);
        wait_tick(1);
        send_bit(1'b0);
        for (int i = 0; i < nbits_cur; i++) begin
            if (i == glitch_bit) begin
                line_drv = d[i]; wait_tick(7);
                line_drv = ~d[i]; wait_tick(1);
                line_drv = d[i]; wait_tick(OVS - 8);
            end else begin
                send_bit(d[i]);
            end
        end
        if (pen) send_bit(pbit);
        line_drv = stopb;
        if (pop_at_push) begin
            wait_tick(10);               // lands on the stop-bit decision tick
            rd_en = 1'b1;
            @(negedge pclk);
            rd_en = 1'b0;
            wait_tick(OVS - 10);
        end else begin
            wait_tick(OVS);
        end
        line_drv = 1'b1;
        wait_tick(OVS);
        if (pop_at_push) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            exp_q.push_back(e);
        end else if (exp_q.size() == DEPTH) begin
            exp_ovr = 1'b1;
        end else begin
            exp_q.push_back(e);
        end
        $display("sent 0x%02h nbits=%0d pen=%0d pbit=%0d stop=%0d", d, nbits_cur, pen, pbit, stopb);
    endtask

    task automatic read_check(input string tag);
        check_val({tag, "_valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_val(tag, {21'd0, rx_bi, rx_fe, rx_pe, rx_data}, {21'd0, exp_q[0]});
            rd_en = 1'b1;
            @(negedge pclk);
            rd_en = 1'b0;
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        int k;
        // ---- reset ----
        repeat (4) @(negedge pclk);
        check_val("rst_count", 32'(fifo_count), 0);
        check_val("rst_valid", 32'(rx_valid), 0);
        check_val("rst_data", 32'(rx_data), 0);
        check_val("rst_busy", 32'(rx_busy), 0);
        check_val("rst_ovr", 32'(overrun), 0);
        presetn = 1'b1;
        repeat (4) @(negedge pclk);

        // ---- basic 8N1 ----
        cfg(2'b11, 0, 0, 0);
        send_frame(8'h55, 0, 1, -1, 0);
        check_val("basic_count", 32'(fifo_count), 1);
        read_check("basic_55");
        check_val("basic_empty_valid", 32'(rx_valid), 0);
        check_val("basic_empty_data", 32'(rx_data), 0);

        // ---- parity ----
        cfg(2'b11, 1, 1, 0);
        send_frame(8'hA5, 1, 1, -1, 0);
        check_val("par_even_bad_pe", 32'(rx_pe), 1);
        read_check("par_even_bad");
        send_frame(8'hA5, 0, 1, -1, 0);
        read_check("par_even_good");
        cfg(2'b11, 1, 0, 1);
        send_frame(8'hA5, 1, 1, -1, 0);
        check_val("par_stick_pe", 32'(rx_pe), 0);
        read_check("par_stick");

        // ---- glitch and voting ----
        cfg(2'b11, 0, 0, 0);
        wait_tick(1);
        line_drv = 1'b0;
        wait_tick(5);
        check_val("glitch_busy_mid", 32'(rx_busy), 1);
        line_drv = 1'b1;
        wait_tick(2 * OVS);
        check_val("glitch_busy", 32'(rx_busy), 0);
        check_val("glitch_count", 32'(fifo_count), 0);
        send_frame(8'h0F, 0, 1, 3, 0);
        read_check("vote_0F");

        // ---- break ----
        cfg(2'b11, 1, 1, 0);
        wait_tick(1);
        line_drv = 1'b0;
        wait_tick(33 * OVS);
        check_val("brk_busy_low", 32'(rx_busy), 1);
        check_val("brk_count_low", 32'(fifo_count), 1);
        line_drv = 1'b1;
        wait_tick(3 * OVS);
        check_val("brk_busy_high", 32'(rx_busy), 0);
        check_val("brk_count_high", 32'(fifo_count), 1);
        exp_q.push_back(model_entry(8'h00, 8, 1, 1, 0, 0, 0));
        read_check("brk_entry");

        // ---- overrun ----
        cfg(2'b11, 0, 0, 0);
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 0, 1, -1, 0);
        check_val("ovr_count", 32'(fifo_count), 16);
        check_val("ovr_flag", 32'(overrun), 32'(exp_ovr));
        for (int i = 0; i < 16; i++) read_check("ovr_drain");
        check_val("ovr_drained_valid", 32'(rx_valid), 0);
        check_val("ovr_sticky", 32'(overrun), 1);
        @(negedge pclk); utrrst = 1'b1; @(negedge pclk); utrrst = 1'b0;
        exp_ovr = 1'b0;
        check_val("ovr_cleared", 32'(overrun), 0);
        for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 0, 1, -1, 0);
        send_frame(8'h30, 0, 1, -1, 1);
        check_val("fullpp_count", 32'(fifo_count), 16);
        check_val("fullpp_ovr", 32'(overrun), 32'(exp_ovr));
        for (int i = 0; i < 16; i++) read_check("fullpp_drain");

        // ---- loopback and utrrst ----
        use_loop = 1'b1;
        cfg(2'b11, 0, 0, 0);
        send_frame(8'h3C, 0, 1, -1, 0);
        read_check("loop_3C_w8");
        cfg(2'b00, 0, 0, 0);
        send_frame(8'h3C, 0, 1, -1, 0);
        read_check("loop_3C_w5");
        cfg(2'b11, 0, 0, 0);
        send_frame(8'h11, 0, 1, -1, 0);
        wait_tick(1);
        line_drv = 1'b0;
        wait_tick(3 * OVS + 5);
        utrrst = 1'b1; @(negedge pclk); utrrst = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        check_val("utr_count", 32'(fifo_count), 0);
        check_val("utr_valid", 32'(rx_valid), 0);
        check_val("utr_busy", 32'(rx_busy), 0);
        check_val("utr_ovr", 32'(overrun), 0);
        line_drv = 1'b1;
        wait_tick(3 * OVS);
        send_frame(8'hC3, 0, 1, -1, 0);
        read_check("utr_next");
        use_loop = 1'b0;

        // ---- randomized frames ----
        for (int it = 0; it < 12; it++) begin
            cfg(2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                d = 8'($urandom);
                send_frame(d, bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), -1, 0);
            end
            check_val("rnd_count", 32'(fifo_count), 32'(exp_q.size()));
            for (int j = 0; j < k; j++) read_check("rnd_entry");
        end

        // ---- asynchronous reset mid-frame ----
        cfg(2'b11, 0, 0, 0);
        send_frame(8'h7E, 0, 1, -1, 0);
        wait_tick(1);
        line_drv = 1'b0;
        wait_tick(40);
        #2 presetn = 1'b0;
        #1;
        check_val("arst_count", 32'(fifo_count), 0);
        check_val("arst_valid", 32'(rx_valid), 0);
        check_val("arst_data", 32'(rx_data), 0);
        check_val("arst_busy", 32'(rx_busy), 0);
        line_drv = 1'b1;
        repeat (3) @(negedge pclk);
        presetn = 1'b1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
